inst_mem: RTL and testbench
===========================

INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 SHALL have parameter IW, default 9, instruction width in bits.
REQ-002 SHALL have parameter AW, default 10, address width in bits (depth 2**AW = 1024 words).
REQ-003 SHALL have parameter HALT_OP, default 9'h1FF, word returned for unloaded addresses.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port reload  input  1  single-cycle request to discard the image and re-enter LOAD.
REQ-007 SHALL have port load_valid  input  1  loader presents load_data.
REQ-008 SHALL have port load_data  input  IW  instruction word to store.
REQ-009 SHALL have port load_last  input  1  marks the final word of the image; qualified by load_valid.
REQ-010 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-011 SHALL have port prog_ctr  input  AW  fetch address from the program counter.
REQ-012 SHALL have port instr  output  IW  registered instruction for the previous cycle's prog_ctr.
REQ-013 SHALL have port fetch_valid  output  1  instr is valid program data.
REQ-014 SHALL have port prog_len  output  AW+1  number of words loaded (0..1024).

Function
REQ-015 SHALL implement two states: LOAD and RUN.
REQ-016 In LOAD, load_ready SHALL be 1 and fetch_valid SHALL be 0; a transfer occurs when load_valid and load_ready are both 1 at a rising edge.
REQ-017 Each transfer SHALL write load_data to mem[wptr], increment wptr, and set prog_len to wptr+1.
REQ-018 A transfer with load_last=1, or the transfer at wptr=2**AW-1, SHALL move the state to RUN on the same edge; words beyond 1024 are never accepted.
REQ-019 A load_last without load_valid SHALL be ignored.
REQ-020 In RUN, load_ready SHALL be 0, and any load_valid SHALL be ignored with no write.
REQ-021 In RUN, each edge SHALL register instr <= mem[prog_ctr] when prog_ctr < prog_len, else HALT_OP; read latency is exactly 1 cycle.
REQ-022 fetch_valid SHALL rise on the first edge in RUN at which instr is loaded, i.e. one cycle after entering RUN, and stay 1 while in RUN.
REQ-023 In LOAD, instr SHALL hold HALT_OP.
REQ-024 reload=1 at an edge SHALL force LOAD, clear wptr and prog_len to 0, set fetch_valid to 0 and instr to HALT_OP. Reload has priority over a simultaneous transfer, which is dropped. Memory contents are not cleared but are unreachable until rewritten.
REQ-025 prog_ctr SHALL be treated as unsigned; no wrap or offset is applied to it.
REQ-026 An image of 0 words is impossible; RUN always has prog_len >= 1.

Reset
REQ-027 Reset=1 SHALL immediately, without waiting for clk, force state LOAD, wptr=0, prog_len=0, load_ready=1, fetch_valid=0, instr=HALT_OP.
REQ-028 Reset asserted mid-load or mid-run SHALL abandon the operation; the next image starts at address 0.
REQ-029 Memory array contents SHALL NOT be reset.

Verification
REQ-030 Sequential load: load words 0x001,0x002,0x003 (last on 0x003), then prog_ctr=0,1,2 on successive cycles -> instr 0x001,0x002,0x003 each one cycle later; prog_len=3; fetch_valid=1.
REQ-031 Out-of-range read: after a 3-word load, prog_ctr=5 -> instr=0x1FF with fetch_valid=1.
REQ-032 Full image: 1024 transfers without load_last -> RUN after the 1024th; prog_len=1024; load_ready=0; a 1025th load_valid is not written.
REQ-033 Reload collision: in LOAD after 2 words, assert reload with load_valid -> prog_len=0, the dropped word is not written, and the next word lands at address 0.
REQ-034 Async reset: assert Reset between clock edges during RUN -> fetch_valid=0, instr=0x1FF, load_ready=1 before the next edge.
REQ-035 Stall: in LOAD with load_valid low for 5 cycles -> wptr and prog_len unchanged; load_last alone does not enter RUN.

Source files
------------

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
//
// Instruction memory with a two-state loader/fetcher.
//
// In LOAD the block accepts a program image one word per transfer
// (load_valid & load_ready) and stores it from address 0 upwards. The image
// ends on a transfer flagged with load_last, or on the transfer that fills
// the final address. The block then switches to RUN.
//
// In RUN the block serves instruction fetches with one cycle of read latency.
// Addresses at or beyond the loaded length return HALT_OP.
//
// A reload pulse or Reset discards the image and returns the block to LOAD.
// The RAM contents survive, but they cannot be read until they are
// overwritten, because fetches are bounded by prog_len.
//
// Ports
//   clk          in   1     sole clock, rising edge
//   Reset        in   1     asynchronous active-high reset
//   reload       in   1     discard image, re-enter LOAD
//   load_valid   in   1     loader presents load_data
//   load_data    in   IW    word to store
//   load_last    in   1     final word of image (qualified by load_valid)
//   load_ready   out  1     block accepts a load word this cycle (LOAD)
//   prog_ctr     in   AW    fetch address (unsigned)
//   instr        out  IW    registered word for previous cycle's prog_ctr
//   fetch_valid  out  1     instr holds valid program data
//   prog_len     out  AW+1  number of words loaded (0 .. 2**AW)
// -----------------------------------------------------------------------------
module inst_mem #(
    parameter int              IW      = 9,
    parameter int              AW      = 10,
    parameter logic [IW-1:0]   HALT_OP = IW'(9'h1FF)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          reload,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [AW-1:0] prog_ctr,
    output logic [IW-1:0] instr,
    output logic          fetch_valid,
    output logic [AW:0]   prog_len
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW:0]   prog_len_q;
    logic [IW-1:0] instr_q;
    logic          fetch_valid_q;

    // The RAM is deliberately left without a reset, so it can map onto a
    // block RAM. Its contents are only reachable below prog_len.
    logic [IW-1:0] mem [DEPTH];

    logic          in_load;
    logic          xfer;
    logic          wr_en;
    logic          last_addr;
    logic          in_range;
    logic [IW-1:0] rd_word_d;

    assign in_load   = (state_q == ST_LOAD);
    assign xfer      = in_load && load_valid;
    assign last_addr = &wptr_q;

    // Reload drops a colliding transfer, and no write may happen while the
    // block is held in reset.
    assign wr_en     = xfer && !reload && !Reset;

    // prog_ctr is compared unsigned against the loaded length.
    assign in_range  = ({1'b0, prog_ctr} < prog_len_q);
    assign rd_word_d = in_range ? mem[prog_ctr] : HALT_OP;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_LOAD;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            instr_q       <= HALT_OP;
            fetch_valid_q <= 1'b0;
        end else if (reload) begin
            state_q       <= ST_LOAD;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            instr_q       <= HALT_OP;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    instr_q       <= HALT_OP;
                    fetch_valid_q <= 1'b0;
                    if (xfer) begin
                        // wptr wraps to 0 on the final address. This is
                        // harmless, because RUN never writes and leaving RUN
                        // always clears wptr.
                        wptr_q     <= wptr_q + AW'(1);
                        prog_len_q <= {1'b0, wptr_q} + (AW+1)'(1);
                        if (load_last || last_addr) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // fetch_valid rises together with the first fetched
                    // word, one edge after RUN is entered.
                    instr_q       <= rd_word_d;
                    fetch_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= ST_LOAD;
                    instr_q       <= HALT_OP;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // load_ready follows the state register directly, so it tracks an
    // asynchronous Reset without waiting for a clock.
    assign load_ready  = in_load;
    assign instr       = instr_q;
    assign fetch_valid = fetch_valid_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_inst_mem.sv
module tb_inst_mem;

    localparam int IW = 9;
    localparam int AW = 10;

    logic          clk;
    logic          Reset;
    logic          reload;
    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic [AW-1:0] prog_ctr;
    logic [IW-1:0] instr;
    logic          fetch_valid;
    logic [AW:0]   prog_len;

    int checks = 0;
    int errors = 0;

    inst_mem #(.IW(IW), .AW(AW), .HALT_OP(9'h1FF)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .reload      (reload),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .prog_ctr    (prog_ctr),
        .instr       (instr),
        .fetch_valid (fetch_valid),
        .prog_len    (prog_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [IW-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        reload     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        prog_ctr   = '0;

        #12;
        check("rst_load_ready",  16'(load_ready),  16'h1);
        check("rst_fetch_valid", 16'(fetch_valid), 16'h0);
        check("rst_instr",       16'(instr),       16'h1FF);
        check("rst_prog_len",    16'(prog_len),    16'h0);
        Reset = 1'b0;

        // Sequential load with a stall between words 2 and 3
        load_word(9'h001, 1'b0);
        load_word(9'h002, 1'b0);
        check("load2_prog_len", 16'(prog_len), 16'd2);
        load_last = 1'b1;
        repeat (5) step();
        load_last = 1'b0;
        check("stall_prog_len",   16'(prog_len),   16'd2);
        check("stall_load_ready", 16'(load_ready), 16'h1);
        load_word(9'h003, 1'b1);
        check("run_prog_len",     16'(prog_len),    16'd3);
        check("run_load_ready",   16'(load_ready),  16'h0);
        check("run_entry_fvalid", 16'(fetch_valid), 16'h0);
        check("run_entry_instr",  16'(instr),       16'h1FF);

        prog_ctr = 10'd0; step();
        check("fetch0", 16'(instr), 16'h001);
        check("fetch0_fvalid", 16'(fetch_valid), 16'h1);
        prog_ctr = 10'd1; step();
        check("fetch1", 16'(instr), 16'h002);
        prog_ctr = 10'd2; step();
        check("fetch2", 16'(instr), 16'h003);
        prog_ctr = 10'd3; step();
        check("fetch3_boundary", 16'(instr), 16'h1FF);
        prog_ctr = 10'd5; step();
        check("fetch5_oor", 16'(instr), 16'h1FF);
        check("fetch5_fvalid", 16'(fetch_valid), 16'h1);

        // Load words offered in RUN are ignored.
        prog_ctr   = 10'd0;
        load_valid = 1'b1;
        load_data  = 9'h0AA;
        step();
        load_valid = 1'b0;
        check("run_ignore_instr",    16'(instr),    16'h001);
        check("run_ignore_prog_len", 16'(prog_len), 16'd3);

        // Asynchronous reset between edges during RUN
        #3 Reset = 1'b1;
        #1;
        check("async_fvalid",     16'(fetch_valid), 16'h0);
        check("async_instr",      16'(instr),       16'h1FF);
        check("async_load_ready", 16'(load_ready),  16'h1);
        check("async_prog_len",   16'(prog_len),    16'h0);
        #1 Reset = 1'b0;

        // Reload colliding with a transfer
        load_word(9'h011, 1'b0);
        load_word(9'h022, 1'b0);
        reload     = 1'b1;
        load_valid = 1'b1;
        load_data  = 9'h033;
        step();
        reload     = 1'b0;
        load_valid = 1'b0;
        check("reload_prog_len",   16'(prog_len),   16'h0);
        check("reload_load_ready", 16'(load_ready), 16'h1);
        load_word(9'h044, 1'b1);
        check("reload_next_len", 16'(prog_len), 16'd1);
        prog_ctr = 10'd0; step();
        check("reload_addr0", 16'(instr), 16'h044);
        prog_ctr = 10'd1; step();
        check("reload_addr1_oor", 16'(instr), 16'h1FF);

        // Reload from RUN, then a full 1024-word image without load_last
        reload = 1'b1; step(); reload = 1'b0;
        check("reload_run_fvalid", 16'(fetch_valid), 16'h0);
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            load_data = 9'(i) ^ 9'h0A5;
            step();
            if (i == 1022) begin
                check("full_1023_len",   16'(prog_len),   16'd1023);
                check("full_1023_ready", 16'(load_ready), 16'h1);
            end
        end
        check("full_prog_len",   16'(prog_len),    16'd1024);
        check("full_load_ready", 16'(load_ready),  16'h0);
        check("full_fvalid",     16'(fetch_valid), 16'h0);

        // A 1025th word must not overwrite address 0 (the wrapped pointer).
        load_data = 9'h123;
        prog_ctr  = 10'd0;
        step();
        load_valid = 1'b0;
        check("full_addr0",   16'(instr),       16'h0A5);
        check("full_fvalid1", 16'(fetch_valid), 16'h1);
        step();
        check("full_addr0_after", 16'(instr), 16'h0A5);
        prog_ctr = 10'd700; step();
        check("full_addr700", 16'(instr), 16'h019);
        prog_ctr = 10'd1023; step();
        check("full_addr1023", 16'(instr), 16'h15A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
